// File: rtl/frame_link_pkg.sv
// frame_link_pkg: shared state encoding, status codes and frame delimiters for frame_link.
package frame_link_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SEND, S_BLANK, S_LISTEN, S_DONE} state_t;
  typedef enum logic [1:0] {ST_OK = 2'b00, ST_TIMEOUT = 2'b01, ST_CHKFAIL = 2'b10, ST_ABORT = 2'b11} status_t;
  localparam logic [5:0] PREAMBLE = 6'b101010;
  localparam logic [3:0] POSTAMBLE = 4'b0101;
endpackage

// File: rtl/frame_serializer.sv
// frame_serializer: MSB-first shifter holding each bit BIT_CYCLES clocks; keeps a copy for resends.
module frame_serializer #(
  parameter int W = 31,
  parameter int BIT_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] frame,
  output logic         dout,
  output logic         last_bit
);
  localparam int BW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
  localparam int IW = $clog2(W);
  logic [W-1:0] saved, shift;
  logic [BW-1:0] bc;
  logic [IW-1:0] idx;
  logic active, bit_end;
  assign bit_end = active && bc == BW'(BIT_CYCLES - 1);
  assign last_bit = bit_end && idx == IW'(W - 1);
  assign dout = active && shift[W-1];
  always_ff @(posedge clk) begin
    if (rst) begin
      saved <= '0;
      shift <= '0;
      bc <= '0;
      idx <= '0;
      active <= 1'b0;
    end else if (abort) begin
      bc <= '0;
      idx <= '0;
      active <= 1'b0;
    end else if (load || start) begin
      if (load) saved <= frame;
      shift <= load ? frame : saved;
      bc <= '0;
      idx <= '0;
      active <= 1'b1;
    end else if (active) begin
      bc <= bit_end ? '0 : bc + 1'b1;
      if (bit_end) begin
        shift <= shift << 1;
        idx <= last_bit ? '0 : idx + 1'b1;
        active <= !last_bit;
      end
    end
  end
endmodule

// File: rtl/frame_link.sv
// frame_link: sends a framed request, listens for a checked reply, retries on timeout or bad checksum.
module frame_link
  import frame_link_pkg::*;
#(
  parameter int PAYLOAD_W = 16,
  parameter int BIT_CYCLES = 200000,
  parameter int BLANK_CYCLES = 1000000,
  parameter int TIMEOUT_CYCLES = 10000000,
  parameter int MAX_RETRY = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 link_en,
  input  logic                 tx_req,
  input  logic [1:0]           tx_mode,
  input  logic [1:0]           tx_type,
  input  logic [PAYLOAD_W-1:0] tx_payload,
  output logic                 dout,
  output logic                 write,
  output logic                 read,
  output logic                 rx_en,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  input  logic                 rx_chk_ok,
  output logic                 done,
  output logic [1:0]           status,
  output logic [7:0]           rx_byte,
  output logic [1:0]           retries,
  output logic                 busy
);
  localparam int FW = PAYLOAD_W + 15;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [1:0] MR = 2'(MAX_RETRY);
  state_t state;
  status_t st;
  logic [TW-1:0] t;
  logic last_bit, abort, load, fail, retry;
  assign abort = (state == S_SEND || state == S_BLANK || state == S_LISTEN) && !link_en;
  assign load = state == S_IDLE && tx_req && link_en;
  // a reply strobe on the timeout cycle is judged on its checksum, not as a timeout
  assign fail = state == S_LISTEN && (rx_valid ? !rx_chk_ok : t == TW'(TIMEOUT_CYCLES - 1));
  assign retry = fail && link_en && retries < MR;
  assign write = state == S_SEND;
  assign read = state == S_BLANK || state == S_LISTEN;
  assign rx_en = state == S_LISTEN;
  assign done = state == S_DONE;
  assign busy = state != S_IDLE;
  assign status = st;
  frame_serializer #(.W(FW), .BIT_CYCLES(BIT_CYCLES)) u_ser (
    .clk(clk),
    .rst(rst),
    .load(load),
    .start(retry),
    .abort(abort),
    .frame({PREAMBLE, tx_mode, tx_type, tx_payload, ^tx_payload, POSTAMBLE}),
    .dout(dout),
    .last_bit(last_bit)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      st <= ST_OK;
      t <= '0;
      rx_byte <= '0;
      retries <= '0;
    end else if (abort) begin
      state <= S_DONE;
      st <= ST_ABORT;
      t <= '0;
    end else begin
      case (state)
        S_IDLE: if (load) begin
          state <= S_SEND;
          retries <= '0;
        end
        S_SEND: if (last_bit) begin
          state <= S_BLANK;
          t <= '0;
        end
        S_BLANK: begin
          t <= t + 1'b1;
          if (t == TW'(BLANK_CYCLES - 1)) state <= S_LISTEN;
        end
        S_LISTEN: if (rx_valid && rx_chk_ok) begin
          rx_byte <= rx_data;
          st <= ST_OK;
          state <= S_DONE;
        end else if (retry) begin
          retries <= retries + 1'b1;
          state <= S_SEND;
        end else if (fail) begin
          st <= rx_valid ? ST_CHKFAIL : ST_TIMEOUT;
          state <= S_DONE;
        end else t <= t + 1'b1;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_link.sv
// tb_frame_link: scenario tasks with a frame/result scoreboard for frame_link.
module tb_frame_link;
  logic clk = 0, rst = 1, link_en = 1, tx_req = 0, rx_valid = 0, rx_chk_ok = 0;
  logic [1:0] tx_mode = 0, tx_type = 0;
  logic [15:0] tx_payload = 0;
  logic [7:0] rx_data = 0;
  logic dout, write, read, rx_en, done, busy;
  logic [1:0] status, retries;
  logic [7:0] rx_byte;
  int vectors = 0, miscompares = 0;
  typedef struct {logic [1:0] st; logic [7:0] rb; logic [1:0] rt;} res_t;
  res_t res_q[$];
  logic [30:0] frame_q[$];

  frame_link #(.PAYLOAD_W(16), .BIT_CYCLES(4), .BLANK_CYCLES(10), .TIMEOUT_CYCLES(50), .MAX_RETRY(2)) dut (
    .clk(clk), .rst(rst), .link_en(link_en), .tx_req(tx_req), .tx_mode(tx_mode), .tx_type(tx_type),
    .tx_payload(tx_payload), .dout(dout), .write(write), .read(read), .rx_en(rx_en),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_chk_ok(rx_chk_ok), .done(done), .status(status),
    .rx_byte(rx_byte), .retries(retries), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [30:0] frm(input logic [1:0] m, input logic [1:0] ty, input logic [15:0] p);
    return {6'b101010, m, ty, p, ^p, 4'b0101};
  endfunction

  function automatic res_t res(input logic [1:0] s, input logic [7:0] b, input logic [1:0] r);
    res_t x;
    x.st = s; x.rb = b; x.rt = r;
    return x;
  endfunction

  task automatic start_tx(input logic [1:0] m, input logic [1:0] ty, input logic [15:0] p);
    @(posedge clk); #1;
    tx_req = 1; tx_mode = m; tx_type = ty; tx_payload = p;
    @(posedge clk); #1;
    tx_req = 0;
    @(negedge clk);
  endtask

  task automatic reply_at(input int k, input logic ok, input logic [7:0] d);
    repeat (k) @(posedge clk);
    #1 rx_valid = 1; rx_chk_ok = ok; rx_data = d;
    @(posedge clk); #1;
    rx_valid = 0; rx_chk_ok = 0;
  endtask

  task automatic check_frame(input int bound);
    logic [30:0] f;
    int n, bad;
    vectors++;
    if (frame_q.size() == 0) begin
      miscompares++;
      $display("FAIL frame_queue empty, a frame was required");
      return;
    end
    f = frame_q.pop_front();
    n = 0;
    while (!write && n < bound) begin @(negedge clk); n++; end
    vectors++;
    if (write !== 1'b1) begin
      miscompares++;
      $display("FAIL frame_start write=%b required 1 within %0d cycles", write, bound);
      return;
    end
    bad = 0;
    for (int i = 0; i < 124; i++) begin
      if (i > 0) @(negedge clk);
      if (dout !== f[30-i/4] || write !== 1'b1) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL frame_bits %0d bad cycles, required 0 for frame %b", bad, f);
    end
    @(negedge clk);
    vectors++;
    if (write !== 0 || dout !== 0 || read !== 1) begin
      miscompares++;
      $display("FAIL frame_end write=%b dout=%b read=%b required 0/0/1", write, dout, read);
    end
  endtask

  task automatic measure_gap();
    int n;
    n = 1;
    while (n < 200) begin
      @(negedge clk);
      if (!read) break;
      n++;
    end
    vectors++;
    if (n != 50 || write !== 1'b1) begin
      miscompares++;
      $display("FAIL listen_gap %0d cycles write=%b, required 50 cycles then write=1", n, write);
    end
  endtask

  task automatic wait_done(input int bound);
    res_t e;
    int n;
    n = 0;
    while (!done && n < bound) begin @(negedge clk); n++; end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL done_wait done=%b required 1 within %0d cycles", done, bound);
      return;
    end
    if (res_q.size() == 0) begin
      miscompares++;
      $display("FAIL done_unexpected status=%b with no result pending", status);
    end else begin
      e = res_q.pop_front();
      if (status !== e.st || rx_byte !== e.rb || retries !== e.rt) begin
        miscompares++;
        $display("FAIL done_result status=%b rx_byte=%h retries=%0d required %b/%h/%0d",
                 status, rx_byte, retries, e.st, e.rb, e.rt);
      end
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 0 || busy !== 0) begin
      miscompares++;
      $display("FAIL done_pulse done=%b busy=%b required 0/0", done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({dout, write, read, rx_en, done, busy, status, rx_byte, retries} !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got %h required 0", {dout, write, read, rx_en, done, busy, status, rx_byte, retries});
    end
    rst = 0;
  endtask

  task automatic test_frame_ok();
    frame_q.push_back(31'b101010_01_10_1010010110100101_0_0101);
    res_q.push_back(res(2'b00, 8'h3C, 2'd0));
    start_tx(2'b01, 2'b10, 16'hA5A5);
    check_frame(5);
    repeat (15) @(posedge clk);
    #1 rx_valid = 1; rx_chk_ok = 1; rx_data = 8'h3C;
    vectors++;
    if (rx_en !== 1'b1 || read !== 1'b1) begin
      miscompares++;
      $display("FAIL listen_window rx_en=%b read=%b required 1/1", rx_en, read);
    end
    @(posedge clk); #1;
    rx_valid = 0; rx_chk_ok = 0;
    wait_done(5);
  endtask

  task automatic test_timeout();
    repeat (3) frame_q.push_back(frm(2'b11, 2'b01, 16'h1234));
    res_q.push_back(res(2'b01, 8'h3C, 2'd2));
    start_tx(2'b11, 2'b01, 16'h1234);
    check_frame(5);
    measure_gap();
    check_frame(1);
    measure_gap();
    check_frame(1);
    wait_done(100);
  endtask

  task automatic test_blank_chkfail();
    repeat (2) frame_q.push_back(frm(2'b00, 2'b11, 16'hFFFE));
    res_q.push_back(res(2'b00, 8'h5A, 2'd1));
    start_tx(2'b00, 2'b11, 16'hFFFE);
    check_frame(5);
    reply_at(5, 1, 8'hFF);
    vectors++;
    if (read !== 1 || rx_en !== 0 || done !== 0 || busy !== 1) begin
      miscompares++;
      $display("FAIL blank_ignore read=%b rx_en=%b done=%b busy=%b required 1/0/0/1", read, rx_en, done, busy);
    end
    reply_at(6, 0, 8'h77);
    vectors++;
    if (write !== 1 || retries !== 2'd1) begin
      miscompares++;
      $display("FAIL chkfail_retry write=%b retries=%0d required 1/1", write, retries);
    end
    @(negedge clk);
    check_frame(1);
    reply_at(12, 1, 8'h5A);
    wait_done(5);
  endtask

  task automatic test_abort();
    res_q.push_back(res(2'b11, 8'h5A, 2'd0));
    start_tx(2'b10, 2'b10, 16'hFFFF);
    repeat (40) @(posedge clk);
    #1 link_en = 0;
    @(posedge clk); #1;
    vectors++;
    if (dout !== 0 || write !== 0 || read !== 0 || rx_en !== 0 || done !== 1) begin
      miscompares++;
      $display("FAIL abort_force dout=%b write=%b read=%b rx_en=%b done=%b required 0/0/0/0/1",
               dout, write, read, rx_en, done);
    end
    wait_done(3);
    tx_req = 1;
    @(posedge clk); #1;
    tx_req = 0;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 0 || write !== 0) begin
      miscompares++;
      $display("FAIL idle_blocked busy=%b write=%b required 0/0", busy, write);
    end
    link_en = 1;
  endtask

  task automatic test_back_to_back();
    frame_q.push_back(frm(2'b10, 2'b01, 16'h0001));
    res_q.push_back(res(2'b00, 8'h81, 2'd0));
    start_tx(2'b10, 2'b01, 16'h0001);
    check_frame(5);
    reply_at(10, 1, 8'h81);
    tx_req = 1; tx_mode = 2'b11; tx_type = 2'b00; tx_payload = 16'h7FFF;
    frame_q.push_back(frm(2'b11, 2'b00, 16'h7FFF));
    res_q.push_back(res(2'b00, 8'h42, 2'd0));
    wait_done(5);
    @(posedge clk); #1;
    tx_req = 0;
    @(negedge clk);
    check_frame(1);
    reply_at(49, 1, 8'h42);
    wait_done(5);
  endtask

  task automatic test_reset_mid();
    int seen;
    frame_q.push_back(frm(2'b01, 2'b01, 16'h00F0));
    start_tx(2'b01, 2'b01, 16'h00F0);
    check_frame(5);
    repeat (12) @(posedge clk);
    #1;
    vectors++;
    if (rx_en !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_listen rx_en=%b required 1", rx_en);
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    vectors++;
    if ({dout, write, read, rx_en, done, busy, status, rx_byte, retries} !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_mid got %h required 0", {dout, write, read, rx_en, done, busy, status, rx_byte, retries});
    end
    seen = 0;
    repeat (20) begin @(negedge clk); if (done || busy) seen++; end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL reset_no_done %0d active cycles required 0", seen);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_frame_ok();
    test_timeout();
    test_blank_chkfail();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    vectors++;
    if (frame_q.size() != 0 || res_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_left frames=%0d results=%0d required 0/0", frame_q.size(), res_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
